state_table_loader: RTL and testbench

- Writer side of the loop-control state table.
- Accepts a host-supplied packet of 48-bit state-table entries over a valid/ready stream, stores them in a register file, and serves them combinationally to the loop FSM, which indexes them with smart_ptr and consumes them as entry_table.
- Gates execution: the FSM sees only invalid entries until the table is fully loaded and explicitly started, and completion is reported back to the host.

---
 rtl/state_table_loader.sv | 85 ++++++++
 tb/tb_state_table_loader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/state_table_loader.sv
// state_table_loader: loads a host packet of state-table entries and exposes it to the loop FSM only while running.
module state_table_loader #(
  parameter int entry_sz_state = 48,
  parameter int dwidth_RFadd = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [entry_sz_state-1:0] s_entry_tdata,
  input  logic                      s_entry_tvalid,
  input  logic                      s_entry_tlast,
  output logic                      s_entry_tready,
  input  logic [dwidth_RFadd-1:0]   smart_ptr,
  output logic [entry_sz_state-1:0] entry_table,
  input  logic                      run_start,
  input  logic                      clear,
  input  logic                      done,
  output logic                      armed,
  output logic                      running,
  output logic                      run_done,
  output logic [dwidth_RFadd:0]     num_entries,
  output logic                      err_overflow
);
  localparam int DEPTH = 2**dwidth_RFadd;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, ARMED, RUN} state_t;
  state_t state, state_nxt;
  logic [dwidth_RFadd-1:0] wr_ptr;
  logic [DEPTH-1:0] occupied;
  logic [entry_sz_state-1:0] mem [DEPTH];
  logic acc;
  assign acc = s_entry_tvalid & s_entry_tready;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = s_entry_tlast ? ARMED : LOAD;
      LOAD:    if (acc) state_nxt = s_entry_tlast ? ARMED : (&wr_ptr ? DRAIN : LOAD);
      DRAIN:   if (acc && s_entry_tlast) state_nxt = IDLE;
      ARMED:   state_nxt = clear ? IDLE : (run_start ? RUN : ARMED);
      RUN:     state_nxt = clear ? IDLE : (done ? ARMED : RUN);
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    s_entry_tready = state == IDLE || state == LOAD || state == DRAIN;
    armed = state == ARMED;
    running = state == RUN;
    entry_table = (state == RUN && occupied[smart_ptr]) ? mem[smart_ptr] : '0;
  end
  always_ff @(posedge clk)
    if (acc && (state == IDLE || state == LOAD))
      mem[state == IDLE ? '0 : wr_ptr] <= s_entry_tdata;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      occupied <= '0;
      num_entries <= '0;
      run_done <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      run_done <= state == RUN && done && !clear;
      if (acc && state == IDLE) begin
        occupied <= DEPTH'(1);
        err_overflow <= 1'b0;
        wr_ptr <= dwidth_RFadd'(1);
        num_entries <= s_entry_tlast ? (dwidth_RFadd+1)'(1) : '0;
      end
      if (acc && state == LOAD) begin
        occupied[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
        if (s_entry_tlast) num_entries <= {1'b0, wr_ptr} + 1'b1;
        else if (&wr_ptr) begin
          err_overflow <= 1'b1;
          occupied <= '0;
          num_entries <= '0;
        end
      end
      // A clear drops the table so a later packet never inherits old occupancy
      if ((state == ARMED || state == RUN) && clear) begin
        occupied <= '0;
        num_entries <= '0;
      end
    end
endmodule

// File: tb/tb_state_table_loader.sv
// tb_state_table_loader: directed vector bench for the state table loader.
module tb_state_table_loader;
  logic clk = 0;
  logic rst = 1;
  logic [47:0] s_entry_tdata = '0;
  logic s_entry_tvalid = 0, s_entry_tlast = 0, s_entry_tready;
  logic [4:0] smart_ptr = '0;
  logic [47:0] entry_table;
  logic run_start = 0, clear = 0, done = 0;
  logic armed, running, run_done, err_overflow;
  logic [5:0] num_entries;
  int n_cmp = 0, n_err = 0;

  localparam logic [47:0] D0 = 48'h1234_5678_9AB1;
  localparam logic [47:0] D1 = 48'hCAFE_F00D_0013;
  localparam logic [47:0] D2 = 48'hDEAD_BEEF_7FFF;

  typedef struct {logic [4:0] ptr; logic [47:0] exp;} vec_t;
  vec_t vec[5];

  always #5 clk = ~clk;

  state_table_loader dut (
    .clk(clk), .rst(rst),
    .s_entry_tdata(s_entry_tdata), .s_entry_tvalid(s_entry_tvalid),
    .s_entry_tlast(s_entry_tlast), .s_entry_tready(s_entry_tready),
    .smart_ptr(smart_ptr), .entry_table(entry_table),
    .run_start(run_start), .clear(clear), .done(done),
    .armed(armed), .running(running), .run_done(run_done),
    .num_entries(num_entries), .err_overflow(err_overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [47:0] d, input logic l);
    s_entry_tdata = d;
    s_entry_tlast = l;
    s_entry_tvalid = 1;
    @(negedge clk);
    s_entry_tvalid = 0;
    s_entry_tlast = 0;
  endtask

  task automatic pulse_start();
    run_start = 1;
    @(negedge clk);
    run_start = 0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 5; i++) begin
      smart_ptr = vec[i].ptr;
      #1 chk($sformatf("%s_ptr%0d", tag, vec[i].ptr), entry_table, vec[i].exp);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tready"}, s_entry_tready, 1);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_run_done"}, run_done, 0);
    chk({tag, "_num"}, num_entries, 0);
    chk({tag, "_ovf"}, err_overflow, 0);
  endtask

  initial begin
    vec[0] = '{5'd0, D0};
    vec[1] = '{5'd1, D1};
    vec[2] = '{5'd2, D2};
    vec[3] = '{5'd3, 48'd0};
    vec[4] = '{5'd4, 48'd0};
    repeat (2) @(negedge clk);
    chk_reset("rst");
    chk("rst_entry", entry_table, 0);
    rst = 0;
    @(negedge clk);
    send(D0, 0);
    chk("load_tready", s_entry_tready, 1);
    chk("load_armed", armed, 0);
    send(D1, 0);
    send(D2, 1);
    chk("armed", armed, 1);
    chk("armed_tready", s_entry_tready, 0);
    chk("armed_num", num_entries, 3);
    smart_ptr = 0;
    #1 chk("armed_entry_hidden", entry_table, 0);
    @(negedge clk);
    done = 1;
    @(negedge clk);
    done = 0;
    chk("armed_done_no_pulse", run_done, 0);
    chk("armed_done_stays", armed, 1);
    pulse_start();
    chk("running", running, 1);
    chk("running_armed", armed, 0);
    sweep("run1");
    chk("run_num", num_entries, 3);
    done = 1;
    @(negedge clk);
    done = 0;
    chk("run_done_pulse", run_done, 1);
    chk("back_armed", armed, 1);
    chk("back_running", running, 0);
    @(negedge clk);
    chk("run_done_one_cycle", run_done, 0);
    pulse_start();
    sweep("run2");
    done = 1;
    @(negedge clk);
    done = 0;
    clear = 1;
    run_start = 1;
    @(negedge clk);
    clear = 0;
    run_start = 0;
    chk("clr_start_tready", s_entry_tready, 1);
    chk("clr_start_running", running, 0);
    chk("clr_start_armed", armed, 0);
    chk("clr_start_num", num_entries, 0);
    for (int i = 0; i < 32; i++) send(48'h1000 + 48'(i), 0);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_num", num_entries, 0);
    chk("ovf_tready", s_entry_tready, 1);
    chk("ovf_armed", armed, 0);
    send(48'hBAD1, 1);
    chk("drain_armed", armed, 0);
    chk("drain_tready", s_entry_tready, 1);
    send(D1, 1);
    chk("one_armed", armed, 1);
    chk("one_num", num_entries, 1);
    chk("one_ovf_cleared", err_overflow, 0);
    pulse_start();
    smart_ptr = 0;
    #1 chk("one_ptr0", entry_table, D1);
    smart_ptr = 1;
    #1 chk("one_ptr1", entry_table, 0);
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("run_clear_running", running, 0);
    chk("run_clear_no_pulse", run_done, 0);
    chk("run_clear_tready", s_entry_tready, 1);
    send(D2, 0);
    send(D0, 0);
    rst = 1;
    @(negedge clk);
    chk_reset("midload_rst");
    rst = 0;
    send(D0, 0);
    send(D2, 1);
    chk("two_armed", armed, 1);
    chk("two_num", num_entries, 2);
    pulse_start();
    smart_ptr = 0;
    #1 chk("two_ptr0", entry_table, D0);
    smart_ptr = 1;
    #1 chk("two_ptr1", entry_table, D2);
    smart_ptr = 2;
    #1 chk("two_ptr2_empty", entry_table, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_reset("midrun_rst");
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
